// File: rtl/udp_rx_conn_filter.sv
// ---------------------------------------------------------------------------
// udp_rx_conn_filter
//
// Purpose: buffers the first KEY_BEAT+1 beats of every received packet, uses
// beat KEY_BEAT as a 64-bit connection lookup key, and on a hit replays the
// buffered header beats followed by a pass-through of the remaining beats,
// tagging every beat with the connection id. On a miss, or for a packet too
// short to contain the key beat, the packet is discarded and counted.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   s_axis_*                 incoming packet stream (tdata/tkeep/tlast)
//   m_lookup_valid/ready/key connection lookup request
//   s_resp_valid/ready       lookup response handshake
//   s_resp_hit, s_resp_id    lookup result (hit flag, connection id)
//   m_axis_*                 filtered packet stream, tuser = connection id
//   fwd_count, drop_count    wrapping packet counters
// ---------------------------------------------------------------------------
module udp_rx_conn_filter #(
  parameter int KEY_BEAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  output logic        m_lookup_valid,
  input  logic        m_lookup_ready,
  output logic [63:0] m_lookup_key,
  input  logic        s_resp_valid,
  output logic        s_resp_ready,
  input  logic        s_resp_hit,
  input  logic [31:0] s_resp_id,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic [31:0] m_axis_tuser,
  output logic [31:0] fwd_count,
  output logic [31:0] drop_count
);

  typedef enum logic [2:0] {
    HDR,
    LOOKUP,
    WAIT,
    REPLAY,
    PASS,
    DROP
  } state_e;

  localparam logic [2:0] KEY_IDX = 3'(KEY_BEAT);

  state_e      state_q, state_d;
  logic [2:0]  hdrIdx_q, hdrIdx_d;
  logic [2:0]  repIdx_q, repIdx_d;
  logic        lastSeen_q, lastSeen_d;
  logic [63:0] key_q, key_d;
  logic [31:0] connId_q, connId_d;
  logic [31:0] fwdCnt_q, fwdCnt_d;
  logic [31:0] dropCnt_q, dropCnt_d;
  logic        bufWrEn;

  // The buffer always has 8 slots so the 3-bit beat index addresses it
  // directly for any legal KEY_BEAT; only slots 0..KEY_BEAT are ever used.
  logic [63:0] hdrData_q [8];
  logic [7:0]  hdrKeep_q [8];

  // Control and counter state; everything returns to a clean HDR on reset
  // so a packet cut short by reset is forgotten rather than counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR;
      hdrIdx_q   <= '0;
      repIdx_q   <= '0;
      lastSeen_q <= 1'b0;
      key_q      <= '0;
      connId_q   <= '0;
      fwdCnt_q   <= '0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdrIdx_q   <= hdrIdx_d;
      repIdx_q   <= repIdx_d;
      lastSeen_q <= lastSeen_d;
      key_q      <= key_d;
      connId_q   <= connId_d;
      fwdCnt_q   <= fwdCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Header buffer is pure datapath: contents are only read back after
  // they have been written for the current packet, so no reset is needed.
  always_ff @(posedge clk) begin
    if (bufWrEn) begin
      hdrData_q[hdrIdx_q] <= s_axis_tdata;
      hdrKeep_q[hdrIdx_q] <= s_axis_tkeep;
    end
  end

  // Next-state and output decode. While rst is high every handshake output
  // is forced low so nothing is accepted or presented during reset.
  always_comb begin
    state_d        = state_q;
    hdrIdx_d       = hdrIdx_q;
    repIdx_d       = repIdx_q;
    lastSeen_d     = lastSeen_q;
    key_d          = key_q;
    connId_d       = connId_q;
    fwdCnt_d       = fwdCnt_q;
    dropCnt_d      = dropCnt_q;
    bufWrEn        = 1'b0;
    s_axis_tready  = 1'b0;
    m_lookup_valid = 1'b0;
    m_lookup_key   = key_q;
    s_resp_ready   = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;

    if (!rst) begin
      case (state_q)
        HDR: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            bufWrEn = 1'b1;
            // The key beat wins over tlast: a packet ending exactly on the
            // key beat is still looked up, just with nothing to pass after.
            if (hdrIdx_q == KEY_IDX) begin
              key_d      = s_axis_tdata;
              lastSeen_d = s_axis_tlast;
              hdrIdx_d   = '0;
              state_d    = LOOKUP;
            end else if (s_axis_tlast) begin
              dropCnt_d = dropCnt_q + 32'd1;
              hdrIdx_d  = '0;
            end else begin
              hdrIdx_d = hdrIdx_q + 3'd1;
            end
          end
        end

        LOOKUP: begin
          m_lookup_valid = 1'b1;
          if (m_lookup_ready) begin
            state_d = WAIT;
          end
        end

        WAIT: begin
          s_resp_ready = 1'b1;
          if (s_resp_valid) begin
            if (s_resp_hit) begin
              connId_d = s_resp_id;
              fwdCnt_d = fwdCnt_q + 32'd1;
              repIdx_d = '0;
              state_d  = REPLAY;
            end else begin
              dropCnt_d = dropCnt_q + 32'd1;
              if (lastSeen_q) begin
                lastSeen_d = 1'b0;
                state_d    = HDR;
              end else begin
                state_d = DROP;
              end
            end
          end
        end

        // Replay outputs come straight from registers, so they stay put
        // for as long as the downstream stalls.
        REPLAY: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdrData_q[repIdx_q];
          m_axis_tkeep  = hdrKeep_q[repIdx_q];
          m_axis_tlast  = (repIdx_q == KEY_IDX) && lastSeen_q;
          m_axis_tuser  = connId_q;
          if (m_axis_tready) begin
            if (repIdx_q == KEY_IDX) begin
              if (lastSeen_q) begin
                lastSeen_d = 1'b0;
                state_d    = HDR;
              end else begin
                state_d = PASS;
              end
            end else begin
              repIdx_d = repIdx_q + 3'd1;
            end
          end
        end

        PASS: begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tkeep  = s_axis_tkeep;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = connId_q;
          if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
            state_d = HDR;
          end
        end

        DROP: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) begin
            state_d = HDR;
          end
        end

        default: begin
          state_d = HDR;
        end
      endcase
    end
  end

  assign fwd_count  = rst ? 32'd0 : fwdCnt_q;
  assign drop_count = rst ? 32'd0 : dropCnt_q;

endmodule

// File: tb/tb_udp_rx_conn_filter.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_conn_filter
//
// Directed bench for udp_rx_conn_filter with KEY_BEAT=1. A source task feeds
// packets, a responder answers lookups with a configurable hit/id/delay, and
// a sink collects forwarded beats (optionally toggling tready) while watching
// that stalled output beats hold steady.
// ---------------------------------------------------------------------------
module tb_udp_rx_conn_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        m_lookup_valid;
  logic        m_lookup_ready;
  logic [63:0] m_lookup_key;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic        s_resp_hit;
  logic [31:0] s_resp_id;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [31:0] m_axis_tuser;
  logic [31:0] fwd_count;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  udp_rx_conn_filter #(.KEY_BEAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .m_lookup_valid (m_lookup_valid),
    .m_lookup_ready (m_lookup_ready),
    .m_lookup_key   (m_lookup_key),
    .s_resp_valid   (s_resp_valid),
    .s_resp_ready   (s_resp_ready),
    .s_resp_hit     (s_resp_hit),
    .s_resp_id      (s_resp_id),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .fwd_count      (fwd_count),
    .drop_count     (drop_count)
  );

  int total = 0;
  int bad = 0;

  // Responder configuration and observations
  logic        respHit = 1'b1;
  logic [31:0] respId = '0;
  int          lookupDelay = 0;
  int          lookupCount = 0;
  int          keyBad = 0;
  logic [63:0] keySeen = '0;

  // Sink configuration and observations
  logic        sinkToggle = 1'b0;
  int          stallBad = 0;
  logic [63:0] outData[$];
  logic [7:0]  outKeep[$];
  logic        outLast[$];
  logic [31:0] outUser[$];

  // Packet under test
  logic [63:0] pktData [8];
  logic [7:0]  pktKeep [8];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives n beats starting at posedge+1; each beat is held until tready is
  // seen high mid-cycle, with a cycle budget per beat.
  task automatic applyStimulus(input int n, input logic endWithLast, output int accepted);
    int   waitCyc;
    logic took;
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pktData[i];
      s_axis_tkeep  = pktKeep[i];
      s_axis_tlast  = endWithLast && (i == n - 1);
      waitCyc = 0;
      took = 1'b0;
      do begin
        @(negedge clk);
        took = s_axis_tready;
        @(posedge clk);
        #1;
        waitCyc++;
      end while (!took && waitCyc < 300);
      if (!took) break;
      accepted++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic waitOut(input int target);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (outData.size() >= target) break;
    end
  endtask

  task automatic checkPacket(input string tag, input int base, input int n, input logic [31:0] id);
    logic [7:0] lastVec;
    logic [7:0] expLast;
    lastVec = '0;
    expLast = 8'(1) << (n - 1);
    for (int i = 0; i < n; i++) begin
      if (base + i < outData.size()) begin
        checkOutput({tag, "_data"}, outData[base+i], pktData[i]);
        checkOutput({tag, "_keep"}, 64'(outKeep[base+i]), 64'(pktKeep[i]));
        checkOutput({tag, "_user"}, 64'(outUser[base+i]), 64'(id));
        lastVec[i] = outLast[base+i];
      end else begin
        checkOutput({tag, "_beat_present"}, 64'(i), 64'(n));
      end
    end
    checkOutput({tag, "_tlast_pattern"}, 64'(lastVec), 64'(expLast));
  endtask

  // Lookup/response agent: grants a pending lookup after lookupDelay
  // cycles, then returns one response while the DUT waits for it.
  initial begin
    m_lookup_ready = 1'b0;
    s_resp_valid   = 1'b0;
    s_resp_hit     = 1'b0;
    s_resp_id      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && m_lookup_valid) begin
        lookupCount++;
        keySeen = m_lookup_key;
        for (int d = 0; d < lookupDelay; d++) begin
          @(posedge clk);
          #1;
          if (!m_lookup_valid || m_lookup_key !== keySeen) keyBad++;
        end
        m_lookup_ready = 1'b1;
        @(posedge clk);
        #1;
        m_lookup_ready = 1'b0;
        s_resp_valid   = 1'b1;
        s_resp_hit     = respHit;
        s_resp_id      = respId;
        @(posedge clk);
        #1;
        s_resp_valid = 1'b0;
      end
    end
  end

  // Output sink: records every transferred beat and flags any change of a
  // beat that was stalled in the previous cycle.
  initial begin
    logic        prevStalled;
    logic [63:0] holdData;
    logic [7:0]  holdKeep;
    logic        holdLast;
    logic [31:0] holdUser;
    prevStalled = 1'b0;
    holdData = '0;
    holdKeep = '0;
    holdLast = 1'b0;
    holdUser = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (prevStalled && m_axis_tvalid) begin
        if (m_axis_tdata !== holdData || m_axis_tkeep !== holdKeep ||
            m_axis_tlast !== holdLast || m_axis_tuser !== holdUser) stallBad++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        outData.push_back(m_axis_tdata);
        outKeep.push_back(m_axis_tkeep);
        outLast.push_back(m_axis_tlast);
        outUser.push_back(m_axis_tuser);
      end
      prevStalled = m_axis_tvalid && !m_axis_tready;
      holdData = m_axis_tdata;
      holdKeep = m_axis_tkeep;
      holdLast = m_axis_tlast;
      holdUser = m_axis_tuser;
      @(posedge clk);
      #1;
      m_axis_tready = sinkToggle ? ~m_axis_tready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int base;
    int lk;

    // Reset behaviour
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("rst_lookup_valid", 64'(m_lookup_valid), 64'd0);
    checkOutput("rst_resp_ready", 64'(s_resp_ready), 64'd0);
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    checkOutput("rst_fwd", 64'(fwd_count), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
    checkOutput("hdr_resp_ready", 64'(s_resp_ready), 64'd0);
    idle(1);

    // A: 4-beat packet, hit id 5
    pktData[0] = 64'h0011_2233_4455_6677; pktKeep[0] = 8'hFF;
    pktData[1] = 64'h0000_0001_0A00_0002; pktKeep[1] = 8'hFF;
    pktData[2] = 64'h8899_AABB_CCDD_EEFF; pktKeep[2] = 8'hFF;
    pktData[3] = 64'h0123_4567_89AB_CDEF; pktKeep[3] = 8'h0F;
    respHit = 1'b1; respId = 32'h5; lookupDelay = 0;
    base = outData.size(); lk = lookupCount;
    applyStimulus(4, 1'b1, acc);
    checkOutput("A_accepted", 64'(acc), 64'd4);
    waitOut(base + 4);
    idle(4);
    checkOutput("A_outcount", 64'(outData.size()), 64'(base + 4));
    checkOutput("A_lookups", 64'(lookupCount - lk), 64'd1);
    checkOutput("A_key", keySeen, 64'h0000_0001_0A00_0002);
    checkPacket("A", base, 4, 32'h5);
    checkOutput("A_fwd", 64'(fwd_count), 64'd1);
    checkOutput("A_drop", 64'(drop_count), 64'd0);

    // B: same packet, miss
    respHit = 1'b0;
    base = outData.size(); lk = lookupCount;
    applyStimulus(4, 1'b1, acc);
    checkOutput("B_accepted", 64'(acc), 64'd4);
    idle(6);
    checkOutput("B_outcount", 64'(outData.size()), 64'(base));
    checkOutput("B_lookups", 64'(lookupCount - lk), 64'd1);
    checkOutput("B_drop", 64'(drop_count), 64'd1);
    checkOutput("B_fwd", 64'(fwd_count), 64'd1);

    // D: hit under toggling backpressure and a 5-cycle lookup delay
    pktData[0] = 64'hDEAD_0000_BEEF_0001; pktKeep[0] = 8'hFF;
    pktData[1] = 64'hC0A8_0102_0000_0035; pktKeep[1] = 8'hFF;
    pktData[2] = 64'h5555_AAAA_5555_AAAA; pktKeep[2] = 8'hFF;
    pktData[3] = 64'h0000_0000_0000_00C3; pktKeep[3] = 8'h01;
    respHit = 1'b1; respId = 32'h33; lookupDelay = 5; sinkToggle = 1'b1;
    base = outData.size(); lk = lookupCount;
    applyStimulus(4, 1'b1, acc);
    checkOutput("D_accepted", 64'(acc), 64'd4);
    waitOut(base + 4);
    idle(6);
    sinkToggle = 1'b0; lookupDelay = 0;
    idle(2);
    checkOutput("D_outcount", 64'(outData.size()), 64'(base + 4));
    checkOutput("D_lookups", 64'(lookupCount - lk), 64'd1);
    checkOutput("D_key", keySeen, 64'hC0A8_0102_0000_0035);
    checkOutput("D_key_stable", 64'(keyBad), 64'd0);
    checkOutput("D_stall_stable", 64'(stallBad), 64'd0);
    checkPacket("D", base, 4, 32'h33);
    checkOutput("D_fwd", 64'(fwd_count), 64'd2);

    // C: runt packet, tlast on beat 0
    pktData[0] = 64'h1234_5678_9ABC_DEF0; pktKeep[0] = 8'h3F;
    base = outData.size(); lk = lookupCount;
    applyStimulus(1, 1'b1, acc);
    checkOutput("C_accepted", 64'(acc), 64'd1);
    idle(5);
    checkOutput("C_lookups", 64'(lookupCount - lk), 64'd0);
    checkOutput("C_outcount", 64'(outData.size()), 64'(base));
    checkOutput("C_drop", 64'(drop_count), 64'd2);
    checkOutput("C_fwd", 64'(fwd_count), 64'd2);

    // E: 2-beat packet ending on the key beat, hit
    pktData[0] = 64'h0102_0304_0506_0708; pktKeep[0] = 8'hFF;
    pktData[1] = 64'hC0A8_0001_0000_1F90; pktKeep[1] = 8'h0F;
    respHit = 1'b1; respId = 32'h77;
    base = outData.size(); lk = lookupCount;
    applyStimulus(2, 1'b1, acc);
    checkOutput("E_accepted", 64'(acc), 64'd2);
    waitOut(base + 2);
    idle(1);
    @(negedge clk);
    checkOutput("E_hdr_tready", 64'(s_axis_tready), 64'd1);
    checkOutput("E_hdr_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    idle(3);
    checkOutput("E_outcount", 64'(outData.size()), 64'(base + 2));
    checkOutput("E_lookups", 64'(lookupCount - lk), 64'd1);
    checkPacket("E", base, 2, 32'h77);
    checkOutput("E_fwd", 64'(fwd_count), 64'd3);

    // F: reset while the packet is in pass-through, then a fresh packet
    pktData[0] = 64'hAAAA_0000_0000_0001; pktKeep[0] = 8'hFF;
    pktData[1] = 64'hBBBB_0000_0000_0002; pktKeep[1] = 8'hFF;
    pktData[2] = 64'hCCCC_0000_0000_0003; pktKeep[2] = 8'hFF;
    respHit = 1'b1; respId = 32'h0000_0042;
    applyStimulus(3, 1'b0, acc);
    checkOutput("F_pre_accepted", 64'(acc), 64'd3);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    checkOutput("F_rst_fwd", 64'(fwd_count), 64'd0);
    checkOutput("F_rst_drop", 64'(drop_count), 64'd0);
    checkOutput("F_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    pktData[0] = 64'h1111_2222_3333_4444; pktKeep[0] = 8'hFF;
    pktData[1] = 64'h5555_6666_7777_8888; pktKeep[1] = 8'hFF;
    pktData[2] = 64'h9999_0000_AAAA_BBBB; pktKeep[2] = 8'h7F;
    respId = 32'hABCD_0009;
    base = outData.size(); lk = lookupCount;
    applyStimulus(3, 1'b1, acc);
    checkOutput("F_accepted", 64'(acc), 64'd3);
    waitOut(base + 3);
    idle(4);
    checkOutput("F_outcount", 64'(outData.size()), 64'(base + 3));
    checkOutput("F_lookups", 64'(lookupCount - lk), 64'd1);
    checkOutput("F_key", keySeen, 64'h5555_6666_7777_8888);
    checkPacket("F", base, 3, 32'hABCD_0009);
    checkOutput("F_fwd", 64'(fwd_count), 64'd1);
    checkOutput("F_drop", 64'(drop_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_conn_filter.md
UDP_RX_CONN_FILTER -- requirements
Module: udp_rx_conn_filter

Interface
REQ-001 SHALL have parameter KEY_BEAT, default 1, giving the 0-based packet beat whose 64-bit tdata is the connection lookup key; legal range 0..7.
REQ-002 SHALL have ports:
  clk  in  1  single clock
  rst  in  1  synchronous, active-high reset
  s_axis_tvalid/tready/tlast  in/out/in  1 each  RX packet stream handshake
  s_axis_tdata  in  64  packet beat
  s_axis_tkeep  in  8  byte enables
  m_lookup_valid  out  1  lookup request valid
  m_lookup_ready  in  1  lookup request accepted
  m_lookup_key  out  64  lookup key
  s_resp_valid  in  1  lookup response valid
  s_resp_ready  out  1  response accepted
  s_resp_hit  in  1  connection found (response bit 32)
  s_resp_id  in  32  connection id (response bits 31:0)
  m_axis_tvalid/tready/tlast  out/in/out  1 each  filtered stream handshake
  m_axis_tdata  out  64  forwarded beat
  m_axis_tkeep  out  8  forwarded byte enables
  m_axis_tuser  out  32  connection id of the packet, constant over all its beats
  fwd_count  out  32  packets forwarded, wraps
  drop_count  out  32  packets dropped (miss or runt), wraps
REQ-003 All transfers SHALL occur only on clk rising edges where valid and ready are both high.

Function
REQ-004 States SHALL be HDR, LOOKUP, WAIT, REPLAY, PASS, DROP.
REQ-005 HDR: s_axis_tready=1; accepted beats (tdata, tkeep) SHALL be stored in header buffer slot hdr_idx, and hdr_idx SHALL increment.
REQ-006 HDR, accepted beat with tlast and hdr_idx<KEY_BEAT (runt): drop_count+1, hdr_idx->0, stay HDR, no lookup issued.
REQ-007 HDR, accepted beat at hdr_idx==KEY_BEAT: key latched from tdata, last_seen latched from tlast, -> LOOKUP; m_lookup_valid SHALL rise the next cycle.
REQ-008 LOOKUP: m_lookup_valid=1, m_lookup_key held stable until accepted; on m_lookup_ready -> WAIT.
REQ-009 WAIT: s_resp_ready=1; on s_resp_valid with hit: latch s_resp_id, fwd_count+1, -> REPLAY.
REQ-010 WAIT, response with miss: drop_count+1, -> HDR if last_seen, else -> DROP.
REQ-011 REPLAY: output buffered beats 0..KEY_BEAT in order, tuser=latched id; m_axis_tlast=1 only on beat KEY_BEAT and only if last_seen. After the last replay beat transfers: -> HDR if last_seen, else -> PASS.
REQ-012 PASS: combinational pass-through, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, data/keep/last copied, tuser=latched id. On tlast transfer -> HDR.
REQ-013 DROP: s_axis_tready=1, m_axis_tvalid=0; beats discarded; on tlast -> HDR.
REQ-014 s_axis_tready SHALL be 0 in LOOKUP, WAIT and REPLAY; m_axis_tvalid SHALL be 0 in HDR, LOOKUP, WAIT and DROP.
REQ-015 On every return to HDR, hdr_idx SHALL be 0 and last_seen SHALL be cleared.
REQ-016 Each of fwd_count and drop_count SHALL increment by at most 1 per cycle and SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 Packet order SHALL be preserved; only one lookup SHALL be outstanding at a time.
REQ-019 An s_resp_valid outside WAIT SHALL be ignored (not accepted).

Reset
REQ-020 While rst=1, the state SHALL be HDR, hdr_idx=0, and all counters=0; m_lookup_valid, s_resp_ready, m_axis_tvalid and m_axis_tlast SHALL be 0, and m_axis_tuser=0.
REQ-021 A rst asserted mid-packet SHALL discard the partial packet without counting it; the next beat after reset SHALL be treated as beat 0.
REQ-022 s_axis_tready SHALL be 0 during the reset cycle and 1 on the first cycle after rst deasserts.

Verification
REQ-023 4-beat packet, key beat=0x0000_0001_0A00_0002, hit, id=0x5 -> key issued once; 4 beats out, tuser=5, tlast on beat 3 only; fwd_count=1.
REQ-024 Same packet, miss -> no m_axis beats; all 4 input beats accepted; drop_count=1; the next packet is processed normally.
REQ-025 1-beat packet (tlast on beat 0, KEY_BEAT=1) -> no lookup; drop_count=1.
REQ-026 2-beat packet ending on the key beat, hit -> 2 beats replayed, tlast on beat 1, no PASS cycle; state returns to HDR.
REQ-027 Hit, with m_axis_tready toggled 1/0 every cycle and lookup ready delayed 5 cycles -> data unchanged under backpressure; no beat lost or duplicated.
REQ-028 rst pulsed during PASS on beat 2 -> counters=0; the following 3-beat packet is forwarded complete with correct tuser.
